// File: rtl/cc_game_event_controller_pkg.sv
// cc_game_event_controller_pkg: shared state encoding, default game constants and output widths
package cc_game_event_controller_pkg;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 2;
    localparam int NEST_W  = 4;

    localparam int LIVES_INIT_DEF   = 3;
    localparam int LIVES_MAX_DEF    = 7;
    localparam int LEVEL_LAST_DEF   = 3;
    localparam int DEATH_TICKS_DEF  = 8;
    localparam int SHIELD_TICKS_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PLAY     = 3'd1;
    localparam state_t ST_DEAD     = 3'd2;
    localparam state_t ST_LEVELUP  = 3'd3;
    localparam state_t ST_GAMEOVER = 3'd4;
    localparam state_t ST_GAMEWON  = 3'd5;

endpackage

// File: rtl/cc_game_event_controller_if.sv
// cc_game_event_controller_if: comparator flags in, game status and command pulses out
//   master : drives start/tick/flags, observes status (comparator + bench side)
//   slave  : the controller itself
interface cc_game_event_controller_if;
    import cc_game_event_controller_pkg::*;

    logic               CC_GAMEEVENT_START_InLow;
    logic               CC_GAMEEVENT_TICK_In;
    logic               CC_GAMEEVENT_LOSE_In;
    logic               CC_GAMEEVENT_WINL_In;
    logic               CC_GAMEEVENT_NEST_In;
    logic               CC_GAMEEVENT_POWERUP_In;
    logic [LIVES_W-1:0] CC_GAMEEVENT_LIVES_Out;
    logic [LEVEL_W-1:0] CC_GAMEEVENT_LEVEL_Out;
    logic [NEST_W-1:0]  CC_GAMEEVENT_NESTCOUNT_Out;
    logic               CC_GAMEEVENT_FROGRESET_Out;
    logic               CC_GAMEEVENT_LEVELLOAD_Out;
    logic               CC_GAMEEVENT_SHIELD_Out;
    logic               CC_GAMEEVENT_PLAYING_Out;
    logic               CC_GAMEEVENT_GAMEOVER_Out;
    logic               CC_GAMEEVENT_GAMEWON_Out;

    modport master (
        output CC_GAMEEVENT_START_InLow, CC_GAMEEVENT_TICK_In, CC_GAMEEVENT_LOSE_In,
               CC_GAMEEVENT_WINL_In, CC_GAMEEVENT_NEST_In, CC_GAMEEVENT_POWERUP_In,
        input  CC_GAMEEVENT_LIVES_Out, CC_GAMEEVENT_LEVEL_Out, CC_GAMEEVENT_NESTCOUNT_Out,
               CC_GAMEEVENT_FROGRESET_Out, CC_GAMEEVENT_LEVELLOAD_Out, CC_GAMEEVENT_SHIELD_Out,
               CC_GAMEEVENT_PLAYING_Out, CC_GAMEEVENT_GAMEOVER_Out, CC_GAMEEVENT_GAMEWON_Out
    );

    modport slave (
        input  CC_GAMEEVENT_START_InLow, CC_GAMEEVENT_TICK_In, CC_GAMEEVENT_LOSE_In,
               CC_GAMEEVENT_WINL_In, CC_GAMEEVENT_NEST_In, CC_GAMEEVENT_POWERUP_In,
        output CC_GAMEEVENT_LIVES_Out, CC_GAMEEVENT_LEVEL_Out, CC_GAMEEVENT_NESTCOUNT_Out,
               CC_GAMEEVENT_FROGRESET_Out, CC_GAMEEVENT_LEVELLOAD_Out, CC_GAMEEVENT_SHIELD_Out,
               CC_GAMEEVENT_PLAYING_Out, CC_GAMEEVENT_GAMEOVER_Out, CC_GAMEEVENT_GAMEWON_Out
    );

endinterface

// File: rtl/cc_game_event_controller_edge_detect.sv
// cc_edge_detect: registers a level flag once and flags its rising edge
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flag_i        : raw level flag
//   edge_o        : high for one cycle after the flag was first registered high
module cc_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flag_i,
    output logic edge_o
);

    logic flag_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            flag_q <= flag_i;
            prev_q <= flag_q;
        end
    end

    assign edge_o = flag_q & ~prev_q;

endmodule

// File: rtl/cc_game_event_controller.sv
// cc_game_event_controller: turns comparator flag edges into lives/level/shield state and frog/background commands
//   CC_GAMEEVENT_CLOCK_50    : system clock
//   CC_GAMEEVENT_RESET_InLow : asynchronous active-low reset
//   bus (slave)              : start/tick/flags in; lives, level, nest count, pulses and status out
module cc_game_event_controller
    import cc_game_event_controller_pkg::*;
#(
    parameter int LIVES_INIT   = LIVES_INIT_DEF,
    parameter int LIVES_MAX    = LIVES_MAX_DEF,
    parameter int LEVEL_LAST   = LEVEL_LAST_DEF,
    parameter int DEATH_TICKS  = DEATH_TICKS_DEF,
    parameter int SHIELD_TICKS = SHIELD_TICKS_DEF
) (
    input logic                       CC_GAMEEVENT_CLOCK_50,
    input logic                       CC_GAMEEVENT_RESET_InLow,
    cc_game_event_controller_if.slave bus
);

    localparam int DEATH_W  = $clog2(DEATH_TICKS + 1);
    localparam int SHIELD_W = $clog2(SHIELD_TICKS + 1);

    logic clk, rst_n, start, tick;
    logic [3:0] flag_vec, ev;

    assign clk      = CC_GAMEEVENT_CLOCK_50;
    assign rst_n    = CC_GAMEEVENT_RESET_InLow;
    assign start    = ~bus.CC_GAMEEVENT_START_InLow;
    assign tick     = bus.CC_GAMEEVENT_TICK_In;
    assign flag_vec = {bus.CC_GAMEEVENT_LOSE_In, bus.CC_GAMEEVENT_WINL_In,
                       bus.CC_GAMEEVENT_NEST_In, bus.CC_GAMEEVENT_POWERUP_In};

    for (genvar i = 0; i < 4; i++) begin : g_edge
        cc_edge_detect u_edge (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .flag_i (flag_vec[i]),
            .edge_o (ev[i])
        );
    end

    state_t              state_q, state_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [NEST_W-1:0]   nest_q, nest_d;
    logic [DEATH_W-1:0]  death_q, death_d;
    logic [SHIELD_W-1:0] shield_q, shield_d;
    logic                frogreset_q, frogreset_d;
    logic                levelload_q, levelload_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lives_q     <= '0;
            level_q     <= '0;
            nest_q      <= '0;
            death_q     <= '0;
            shield_q    <= '0;
            frogreset_q <= 1'b0;
            levelload_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            nest_q      <= nest_d;
            death_q     <= death_d;
            shield_q    <= shield_d;
            frogreset_q <= frogreset_d;
            levelload_q <= levelload_d;
        end
    end

    // ev[3]=lose, ev[2]=winL, ev[1]=nest, ev[0]=powerup; the if-chain in PLAY is the priority order
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        nest_d      = nest_q;
        death_d     = death_q;
        frogreset_d = 1'b0;
        levelload_d = 1'b0;
        // Shield only runs down while actually playing; events below may override it
        shield_d    = (state_q == ST_PLAY && tick && shield_q != '0) ? shield_q - 1'b1 : shield_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PLAY;
                    lives_d     = LIVES_W'(LIVES_INIT);
                    level_d     = '0;
                    nest_d      = '0;
                    shield_d    = '0;
                    frogreset_d = 1'b1;
                    levelload_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (ev[3]) begin
                    if (shield_q == '0) begin
                        lives_d = lives_q - 1'b1;
                        death_d = DEATH_W'(DEATH_TICKS);
                        state_d = (lives_q == LIVES_W'(1)) ? ST_GAMEOVER : ST_DEAD;
                    end
                end else if (ev[2]) begin
                    if (level_q == LEVEL_W'(LEVEL_LAST)) begin
                        state_d = ST_GAMEWON;
                    end else begin
                        state_d     = ST_LEVELUP;
                        level_d     = level_q + 1'b1;
                        nest_d      = '0;
                        shield_d    = '0;
                        frogreset_d = 1'b1;
                        levelload_d = 1'b1;
                    end
                end else if (ev[1]) begin
                    nest_d      = (nest_q == '1) ? nest_q : nest_q + 1'b1;
                    frogreset_d = 1'b1;
                end else if (ev[0]) begin
                    lives_d  = (lives_q >= LIVES_W'(LIVES_MAX)) ? lives_q : lives_q + 1'b1;
                    shield_d = SHIELD_W'(SHIELD_TICKS);
                end
            end
            ST_DEAD: begin
                if (tick) begin
                    death_d = (death_q <= DEATH_W'(1)) ? '0 : death_q - 1'b1;
                    if (death_q <= DEATH_W'(1)) begin
                        state_d     = ST_PLAY;
                        frogreset_d = 1'b1;
                    end
                end
            end
            ST_LEVELUP: state_d = ST_PLAY;
            ST_GAMEOVER, ST_GAMEWON: state_d = start ? ST_IDLE : state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.CC_GAMEEVENT_LIVES_Out     = lives_q;
        bus.CC_GAMEEVENT_LEVEL_Out     = level_q;
        bus.CC_GAMEEVENT_NESTCOUNT_Out = nest_q;
        bus.CC_GAMEEVENT_FROGRESET_Out = frogreset_q;
        bus.CC_GAMEEVENT_LEVELLOAD_Out = levelload_q;
        bus.CC_GAMEEVENT_SHIELD_Out    = shield_q != '0;
        bus.CC_GAMEEVENT_PLAYING_Out   = state_q == ST_PLAY;
        bus.CC_GAMEEVENT_GAMEOVER_Out  = state_q == ST_GAMEOVER;
        bus.CC_GAMEEVENT_GAMEWON_Out   = state_q == ST_GAMEWON;
    end

endmodule

// File: tb/tb_cc_game_event_controller.sv
// tb_cc_game_event_controller: directed test-plan scenarios plus random play against a cycle reference model
module tb_cc_game_event_controller;

    localparam int DEATH_TICKS  = 8;
    localparam int SHIELD_TICKS = 32;

    typedef enum int {M_IDLE, M_PLAY, M_DEAD, M_LVUP, M_OVER, M_WON} mstate_t;

    logic clk, rst_n;
    logic start_n, tick, lose, winl, nest, pwr;
    int   n_checks = 0;
    int   n_err    = 0;

    cc_game_event_controller_if bus ();

    assign bus.CC_GAMEEVENT_START_InLow = start_n;
    assign bus.CC_GAMEEVENT_TICK_In     = tick;
    assign bus.CC_GAMEEVENT_LOSE_In     = lose;
    assign bus.CC_GAMEEVENT_WINL_In     = winl;
    assign bus.CC_GAMEEVENT_NEST_In     = nest;
    assign bus.CC_GAMEEVENT_POWERUP_In  = pwr;

    cc_game_event_controller dut (
        .CC_GAMEEVENT_CLOCK_50    (clk),
        .CC_GAMEEVENT_RESET_InLow (rst_n),
        .bus                      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: game rules applied once per clock edge
    mstate_t m_state = M_IDLE;
    int m_lives = 0, m_level = 0, m_nest = 0, m_shield = 0, m_death = 0;
    bit m_fr = 0, m_ll = 0;
    bit [3:0] seen1 = 0, seen2 = 0;

    task automatic model_step();
        bit [3:0] ev;
        int sh;
        m_fr = 0;
        m_ll = 0;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_lives = 0; m_level = 0; m_nest = 0; m_shield = 0; m_death = 0;
            seen1 = 0; seen2 = 0;
            return;
        end
        ev    = seen1 & ~seen2;
        seen2 = seen1;
        seen1 = {lose, winl, nest, pwr};
        case (m_state)
            M_IDLE: if (!start_n) begin
                m_state = M_PLAY;
                m_lives = 3; m_level = 0; m_nest = 0; m_shield = 0;
                m_fr = 1; m_ll = 1;
            end
            M_PLAY: begin
                sh = (tick && m_shield > 0) ? m_shield - 1 : m_shield;
                if (ev[3]) begin
                    if (m_shield == 0) begin
                        m_lives--;
                        if (m_lives == 0) m_state = M_OVER;
                        else begin m_state = M_DEAD; m_death = DEATH_TICKS; end
                    end
                end else if (ev[2]) begin
                    if (m_level == 3) m_state = M_WON;
                    else begin
                        m_level++; m_nest = 0; sh = 0; m_state = M_LVUP;
                        m_fr = 1; m_ll = 1;
                    end
                end else if (ev[1]) begin
                    m_nest = (m_nest < 15) ? m_nest + 1 : 15;
                    m_fr = 1;
                end else if (ev[0]) begin
                    m_lives = (m_lives < 7) ? m_lives + 1 : 7;
                    sh = SHIELD_TICKS;
                end
                m_shield = sh;
            end
            M_DEAD: if (tick) begin
                m_death--;
                if (m_death == 0) begin m_state = M_PLAY; m_fr = 1; end
            end
            M_LVUP: m_state = M_PLAY;
            default: if (!start_n) m_state = M_IDLE;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("m_lives",    32'(bus.CC_GAMEEVENT_LIVES_Out),     m_lives);
            check("m_level",    32'(bus.CC_GAMEEVENT_LEVEL_Out),     m_level);
            check("m_nest",     32'(bus.CC_GAMEEVENT_NESTCOUNT_Out), m_nest);
            check("m_frogrst",  32'(bus.CC_GAMEEVENT_FROGRESET_Out), 32'(m_fr));
            check("m_lvload",   32'(bus.CC_GAMEEVENT_LEVELLOAD_Out), 32'(m_ll));
            check("m_shield",   32'(bus.CC_GAMEEVENT_SHIELD_Out),    32'(m_shield != 0));
            check("m_playing",  32'(bus.CC_GAMEEVENT_PLAYING_Out),   32'(m_state == M_PLAY));
            check("m_gameover", 32'(bus.CC_GAMEEVENT_GAMEOVER_Out),  32'(m_state == M_OVER));
            check("m_gamewon",  32'(bus.CC_GAMEEVENT_GAMEWON_Out),   32'(m_state == M_WON));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    // f = {lose, winl, nest, pwr}; returns after the edge has been acted on
    task automatic edge_in(input logic [3:0] f);
        {lose, winl, nest, pwr} = f;
        cyc(1);
        {lose, winl, nest, pwr} = 4'b0;
        cyc(1);
    endtask

    task automatic start_game(input int n);
        start_n = 1'b0;
        cyc(n);
        start_n = 1'b1;
    endtask

    task automatic die_respawn();
        edge_in(4'b1000);
        repeat (DEATH_TICKS) tick_once();
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0; start_n = 1'b1; tick = 1'b0;
        {lose, winl, nest, pwr} = 4'b0;
        cyc(3);
        check("rst_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 0);
        check("rst_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 0);
        check("rst_frogrst", 32'(bus.CC_GAMEEVENT_FROGRESET_Out), 0);
        rst_n = 1'b1;
        cyc(1);

        start_game(1);
        check("start_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 3);
        check("start_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 1);
        check("start_frogrst", 32'(bus.CC_GAMEEVENT_FROGRESET_Out), 1);
        check("start_lvload", 32'(bus.CC_GAMEEVENT_LEVELLOAD_Out), 1);
        cyc(1);
        check("start_frogrst_end", 32'(bus.CC_GAMEEVENT_FROGRESET_Out), 0);
        check("start_lvload_end", 32'(bus.CC_GAMEEVENT_LEVELLOAD_Out), 0);

        lose = 1'b1;
        cyc(5);
        lose = 1'b0;
        check("held_lose_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 2);
        check("dead_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 0);
        repeat (DEATH_TICKS - 1) tick_once();
        check("dead_7ticks", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 0);
        tick_once();
        check("respawn_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 1);
        check("respawn_frogrst", 32'(bus.CC_GAMEEVENT_FROGRESET_Out), 1);
        cyc(1);

        edge_in(4'b0001);
        check("pwr_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 3);
        check("pwr_shield", 32'(bus.CC_GAMEEVENT_SHIELD_Out), 1);
        edge_in(4'b1000);
        check("shield_lose_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 3);
        check("shield_lose_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 1);
        repeat (SHIELD_TICKS - 1) tick_once();
        check("shield_31", 32'(bus.CC_GAMEEVENT_SHIELD_Out), 1);
        tick_once();
        check("shield_32", 32'(bus.CC_GAMEEVENT_SHIELD_Out), 0);

        die_respawn();
        die_respawn();
        check("one_life", 32'(bus.CC_GAMEEVENT_LIVES_Out), 1);
        edge_in(4'b1100);
        check("prio_gameover", 32'(bus.CC_GAMEEVENT_GAMEOVER_Out), 1);
        check("prio_level", 32'(bus.CC_GAMEEVENT_LEVEL_Out), 0);

        start_game(2);
        check("restart_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 3);
        for (int k = 1; k <= 3; k++) begin
            edge_in(4'b0100);
            check("winl_level", 32'(bus.CC_GAMEEVENT_LEVEL_Out), 32'(k));
            check("winl_lvload", 32'(bus.CC_GAMEEVENT_LEVELLOAD_Out), 1);
            cyc(1);
            check("winl_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 1);
        end
        edge_in(4'b0100);
        check("gamewon", 32'(bus.CC_GAMEEVENT_GAMEWON_Out), 1);
        check("gamewon_level", 32'(bus.CC_GAMEEVENT_LEVEL_Out), 3);

        start_game(2);
        edge_in(4'b1000);
        repeat (4) tick_once();
        rst_n = 1'b0;
        #1;
        check("midrst_lives", 32'(bus.CC_GAMEEVENT_LIVES_Out), 0);
        check("midrst_gameover", 32'(bus.CC_GAMEEVENT_GAMEOVER_Out), 0);
        check("midrst_playing", 32'(bus.CC_GAMEEVENT_PLAYING_Out), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        start_game(1);
        check("midrst_restart", 32'(bus.CC_GAMEEVENT_LIVES_Out), 3);

        repeat (4000) begin
            rst_n   = $urandom_range(0, 799) != 0;
            start_n = $urandom_range(0, 24) != 0;
            tick    = $urandom_range(0, 3) == 0;
            lose    = $urandom_range(0, 9) == 0;
            winl    = $urandom_range(0, 19) == 0;
            nest    = $urandom_range(0, 5) == 0;
            pwr     = $urandom_range(0, 11) == 0;
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
